// File: rtl/entrada_dados.sv
// Processor input stage: stalls on InRead until the user presses Enter,
// then returns the debounced, extended switch value with a 4-phase handshake.
module entrada_dados #(
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit SIGN_EXT        = 1'b1
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                InRead,
  input  logic [SW_WIDTH-1:0] Switches,
  input  logic                Enter,
  output logic [31:0]         Dado,
  output logic                Ready,
  output logic                Stall,
  output logic                WaitLED
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RELEASE,
    WAIT_PRESS,
    DONE
  } state_t;

  state_t state;

  logic                en_m;
  logic                en_s;
  logic [SW_WIDTH-1:0] sw_m;
  logic [SW_WIDTH-1:0] sw_s;
  logic                en_stable;
  logic [CW-1:0]       cnt;
  logic                flip;
  logic                press_evt;
  logic [31:0]         ext;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      en_m <= 1'b1;
      en_s <= 1'b1;
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      en_m <= Enter;
      en_s <= en_m;
      sw_m <= Switches;
      sw_s <= sw_m;
    end
  end

  assign flip      = (en_s != en_stable) && (cnt == CNT_MAX);
  assign press_evt = flip && en_stable;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cnt       <= '0;
      en_stable <= 1'b1;
    end else if (en_s == en_stable) begin
      cnt <= '0;
    end else if (flip) begin
      cnt       <= '0;
      en_stable <= ~en_stable;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  generate
    if (SW_WIDTH >= 32) begin : g_full
      assign ext = sw_s[31:0];
    end else if (SIGN_EXT) begin : g_sext
      assign ext = {{(32-SW_WIDTH){sw_s[SW_WIDTH-1]}}, sw_s};
    end else begin : g_zext
      assign ext = {{(32-SW_WIDTH){1'b0}}, sw_s};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state   <= IDLE;
      Dado    <= '0;
      Ready   <= 1'b0;
      WaitLED <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (InRead) begin
            state   <= en_stable ? WAIT_PRESS : WAIT_RELEASE;
            WaitLED <= 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!InRead) begin
            state   <= IDLE;
            WaitLED <= 1'b0;
          end else if (en_stable) begin
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!InRead) begin
            state   <= IDLE;
            WaitLED <= 1'b0;
          end else if (press_evt) begin
            state   <= DONE;
            Dado    <= ext;
            Ready   <= 1'b1;
            WaitLED <= 1'b0;
          end
        end
        DONE: begin
          if (!InRead) begin
            state <= IDLE;
            Ready <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          Ready   <= 1'b0;
          WaitLED <= 1'b0;
        end
      endcase
    end
  end

  assign Stall = InRead & ~Ready;

endmodule

// File: tb/tb_entrada_dados.sv
// Directed bench for entrada_dados with short debounce;
// a zero-extending twin shares all inputs.
module tb_entrada_dados;

  logic        clk;
  logic        rst;
  logic        inread;
  logic [9:0]  sw;
  logic        enter;
  logic [31:0] dado;
  logic        ready;
  logic        stall;
  logic        waitled;
  logic [31:0] dado0;
  logic        ready0;
  logic        stall0;
  logic        waitled0;

  int n_run;
  int n_fail;

  entrada_dados #(
    .SW_WIDTH(10), .DEBOUNCE_CYCLES(4), .SIGN_EXT(1'b1)
  ) dut (
    .CLK(clk), .Reset(rst), .InRead(inread),
    .Switches(sw), .Enter(enter), .Dado(dado),
    .Ready(ready), .Stall(stall), .WaitLED(waitled)
  );

  entrada_dados #(
    .SW_WIDTH(10), .DEBOUNCE_CYCLES(4), .SIGN_EXT(1'b0)
  ) dut0 (
    .CLK(clk), .Reset(rst), .InRead(inread),
    .Switches(sw), .Enter(enter), .Dado(dado0),
    .Ready(ready0), .Stall(stall0), .WaitLED(waitled0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int n);
    enter = 1'b0;
    tick(n);
    enter = 1'b1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b0;
    inread = 1'b0;
    sw     = '0;
    enter  = 1'b1;

    // 1: reset
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rst_dado", dado, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wled", {31'd0, waitled}, 32'd0);

    // 2: basic capture and handshake
    sw     = 10'd25;
    inread = 1'b1;
    #1;
    chk("t2_stall_rise", {31'd0, stall}, 32'd1);
    tick(1);
    chk("t2_wled", {31'd0, waitled}, 32'd1);
    press(10);
    chk("t2_dado", dado, 32'd25);
    chk("t2_ready", {31'd0, ready}, 32'd1);
    chk("t2_stall", {31'd0, stall}, 32'd0);
    chk("t2_wled_off", {31'd0, waitled}, 32'd0);
    tick(8);
    chk("t2_ready_hold", {31'd0, ready}, 32'd1);
    inread = 1'b0;
    tick(1);
    chk("t2_ready_drop", {31'd0, ready}, 32'd0);

    // 3: sign vs zero extension
    sw     = 10'h3FF;
    inread = 1'b1;
    tick(1);
    press(10);
    tick(8);
    chk("t3_sext", dado, 32'hFFFF_FFFF);
    chk("t3_zext", dado0, 32'h0000_03FF);
    inread = 1'b0;
    tick(1);

    // 4: short glitch during WAIT_PRESS, then abort
    sw     = 10'd9;
    inread = 1'b1;
    tick(3);
    press(2);
    tick(10);
    chk("t4_ready", {31'd0, ready}, 32'd0);
    chk("t4_wled", {31'd0, waitled}, 32'd1);
    chk("t4_stall", {31'd0, stall}, 32'd1);
    inread = 1'b0;
    tick(1);
    chk("t4_abort_wled", {31'd0, waitled}, 32'd0);
    chk("t4_abort_dado", dado, 32'hFFFF_FFFF);

    // 5: key held before request
    enter = 1'b0;
    tick(10);
    sw     = 10'd5;
    inread = 1'b1;
    tick(10);
    chk("t5_held_ready", {31'd0, ready}, 32'd0);
    chk("t5_held_wled", {31'd0, waitled}, 32'd1);
    enter = 1'b1;
    tick(10);
    chk("t5_rel_ready", {31'd0, ready}, 32'd0);
    sw = 10'h2AA;
    press(10);
    chk("t5_sext", dado, 32'hFFFF_FEAA);
    chk("t5_zext", dado0, 32'h0000_02AA);
    tick(8);
    inread = 1'b0;
    tick(1);

    // 6: reset mid-wait, then recapture
    sw     = 10'd7;
    inread = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("t6_rst_dado", dado, 32'd0);
    chk("t6_rst_ready", {31'd0, ready}, 32'd0);
    chk("t6_rst_wled", {31'd0, waitled}, 32'd0);
    rst = 1'b1;
    tick(2);
    chk("t6_rewait", {31'd0, waitled}, 32'd1);
    press(10);
    chk("t6_dado", dado, 32'd7);
    chk("t6_ready", {31'd0, ready}, 32'd1);
    sw = 10'd0;
    tick(5);
    chk("t6_dado_hold", dado, 32'd7);
    inread = 1'b0;
    tick(1);
    chk("t6_ready_drop", {31'd0, ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
